// File: rtl/spi_master_if.sv
// Host request bus for spi_master.
// The master modport is the host side; the slave modport is the block side.
interface spi_master_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_master.sv
// SPI initiator for the slave register protocol: 24-bit frames {ID, addr, data}.
// Optional abort support is enabled with SPI_MASTER_ABORT_EN.
module spi_master #(
    parameter int         HALF_PERIOD = 8,
    parameter int         GAP_CYCLES  = 8,
    parameter logic [7:0] SLAVE_IDW   = 8'hFF,
    parameter logic [7:0] SLAVE_IDR   = 8'h00
) (
    input  logic          clock,
    input  logic          n_reset,
    spi_master_if.slave   host,
    output logic          ss,
    output logic          sclk,
    output logic          mosi,
    input  logic          miso
`ifdef SPI_MASTER_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [15:0] H_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] G_LAST = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [4:0]  bit_cnt;
    logic        high;
    logic [23:0] shreg;
    logic [7:0]  rx;
    logic        rd;
`ifdef SPI_MASTER_ABORT_EN
    logic        abt;
`endif

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            high       <= 1'b0;
            shreg      <= '0;
            rx         <= '0;
            rd         <= 1'b0;
            ss         <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            host.busy  <= 1'b0;
            host.done  <= 1'b0;
            host.rdata <= '0;
`ifdef SPI_MASTER_ABORT_EN
            abt        <= 1'b0;
            aborted    <= 1'b0;
`endif
        end else begin
            host.done <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
            aborted   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (host.start) begin
                        shreg <= {host.rw ? SLAVE_IDR : SLAVE_IDW,
                                  host.addr,
                                  host.rw ? 8'h00 : host.wdata};
                        mosi      <= host.rw ? SLAVE_IDR[7] : SLAVE_IDW[7];
                        rd        <= host.rw;
                        ss        <= 1'b0;
                        sclk      <= 1'b0;
                        host.busy <= 1'b1;
                        cnt       <= '0;
                        bit_cnt   <= '0;
                        high      <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == H_LAST) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        high  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt != H_LAST) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= '0;
                        if (high) begin
                            // falling edge: advance MOSI, capture MISO of data byte
                            high  <= 1'b0;
                            sclk  <= 1'b0;
                            shreg <= {shreg[22:0], 1'b0};
                            mosi  <= shreg[22];
                            if (bit_cnt >= 5'd16)
                                rx <= {rx[6:0], miso};
                        end else if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            mosi    <= 1'b0;
                            state   <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            high    <= 1'b1;
                            sclk    <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == H_LAST) begin
                        cnt   <= '0;
                        ss    <= 1'b1;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == G_LAST) begin
                        cnt       <= '0;
                        host.busy <= 1'b0;
                        host.done <= 1'b1;
                        state     <= IDLE;
`ifdef SPI_MASTER_ABORT_EN
                        aborted   <= abt;
                        abt       <= 1'b0;
                        if (rd && !abt)
                            host.rdata <= rx;
`else
                        if (rd)
                            host.rdata <= rx;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SPI_MASTER_ABORT_EN
            if (abort && (state == SETUP || state == SHIFT || state == HOLD)) begin
                sclk    <= 1'b0;
                mosi    <= 1'b0;
                ss      <= 1'b1;
                high    <= 1'b0;
                cnt     <= '0;
                bit_cnt <= '0;
                abt     <= 1'b1;
                state   <= GAP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural SPI register slave.
module tb_spi_master;

    logic clock = 1'b0;
    logic n_reset = 1'b0;
    logic ss, sclk, mosi;
    logic miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
`endif

    spi_master_if hif ();

    spi_master dut (
        .clock   (clock),
        .n_reset (n_reset),
        .host    (hif),
        .ss      (ss),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
`ifdef SPI_MASTER_ABORT_EN
        ,
        .abort   (abort),
        .aborted (aborted)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural slave: shifts MOSI on SCLK rise, drives MISO on SCLK fall.
    logic [7:0]  mem [256];
    logic [23:0] sframe = '0;
    logic [23:0] last_frame = '0;
    logic [7:0]  rbyte = '0;
    int srises = 0;
    int last_rises = 0;
    int nframes = 0;
    int viol = 0;
    int hi_run = 0;
    int last_gap = 0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always @(negedge ss) begin
        srises = 0;
        sframe = '0;
        nframes++;
    end

    always @(posedge sclk) begin
        if (ss === 1'b1) viol++;
        else begin
            sframe = {sframe[22:0], mosi};
            srises++;
            if (srises == 16) rbyte = mem[sframe[7:0]];
        end
    end

    always @(negedge sclk)
        if (ss === 1'b0 && srises >= 16 && srises <= 23)
            miso = rbyte[23 - srises];

    always @(posedge ss) begin
        last_frame = sframe;
        last_rises = srises;
        if (srises == 24 && sframe[23:16] == 8'hFF)
            mem[sframe[15:8]] = sframe[7:0];
    end

    always @(negedge clock) begin
        if (ss === 1'b1) hi_run++;
        else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    // Called at a negedge; returns at the negedge of the first non-busy cycle.
    task automatic txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                       output int bcyc, output logic dn, output logic [7:0] rdv);
        hif.start = 1'b1;
        hif.rw    = r;
        hif.addr  = a;
        hif.wdata = d;
        @(negedge clock);
        hif.start = 1'b0;
        bcyc = 0;
        while (hif.busy === 1'b1 && bcyc < 2000) begin
            bcyc++;
            @(negedge clock);
        end
        dn  = hif.done;
        rdv = hif.rdata;
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [23:0] frame;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int         bc;
        int         nf;
        int         n;
        logic       dn;
        logic [7:0] rdv;

        vecs[0] = '{1'b0, 8'h10, 8'hA5, 24'hFF10A5, 8'h00};
        vecs[1] = '{1'b1, 8'h10, 8'h5A, 24'h001000, 8'hA5};
        vecs[2] = '{1'b0, 8'h13, 8'h3C, 24'hFF133C, 8'hA5};
        vecs[3] = '{1'b1, 8'h12, 8'hFF, 24'h001200, 8'h00};
        vecs[4] = '{1'b0, 8'h20, 8'h77, 24'hFF2077, 8'h00};
        vecs[5] = '{1'b1, 8'h13, 8'h00, 24'h001300, 8'h3C};
        vecs[6] = '{1'b1, 8'h20, 8'h00, 24'h002000, 8'h77};

        hif.start = 1'b0;
        hif.rw    = 1'b0;
        hif.addr  = '0;
        hif.wdata = '0;
        #12;
        chk("rst_ss", 32'(ss), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(hif.busy), 32'd0);
        chk("rst_done", 32'(hif.done), 32'd0);
        chk("rst_rdata", 32'(hif.rdata), 32'd0);
`ifdef SPI_MASTER_ABORT_EN
        chk("rst_aborted", 32'(aborted), 32'd0);
`endif
        @(negedge clock);
        n_reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, bc, dn, rdv);
            chk($sformatf("v%0d_frame", i), 32'(last_frame), 32'(vecs[i].frame));
            chk($sformatf("v%0d_rises", i), 32'(last_rises), 32'd24);
            chk($sformatf("v%0d_busy", i), 32'(bc), 32'd408);
            chk($sformatf("v%0d_done", i), 32'(dn), 32'd1);
            chk($sformatf("v%0d_rdata", i), 32'(rdv), 32'(vecs[i].rdata));
        end
        @(negedge clock);
        chk("done_pulse_width", 32'(hif.done), 32'd0);

        // start while busy is ignored
        nf = nframes;
        hif.start = 1'b1;
        hif.rw    = 1'b0;
        hif.addr  = 8'h30;
        hif.wdata = 8'h42;
        @(negedge clock);
        hif.start = 1'b0;
        repeat (4) @(negedge clock);
        hif.start = 1'b1;
        hif.addr  = 8'h55;
        hif.wdata = 8'hEE;
        @(negedge clock);
        hif.start = 1'b0;
        n = 0;
        while (hif.busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clock);
        end
        chk("ign_frames", 32'(nframes - nf), 32'd1);
        chk("ign_frame", 32'(last_frame), 32'hFF3042);
        chk("ign_done", 32'(hif.done), 32'd1);
        repeat (2) @(negedge clock);
        chk("ign_idle", 32'(hif.busy), 32'd0);

        // back-to-back: second start lands in the done cycle
        @(negedge clock);
        nf = nframes;
        txn(1'b0, 8'h21, 8'h11, bc, dn, rdv);
        chk("b2b_done1", 32'(dn), 32'd1);
        txn(1'b1, 8'h21, 8'h00, bc, dn, rdv);
        chk("b2b_frames", 32'(nframes - nf), 32'd2);
        chk("b2b_busy2", 32'(bc), 32'd408);
        chk("b2b_rdata", 32'(rdv), 32'h11);
        chk("b2b_gap_ok", 32'(last_gap >= 8), 32'd1);

        // asynchronous reset at bit 10 of a write
        @(negedge clock);
        hif.start = 1'b1;
        hif.rw    = 1'b0;
        hif.addr  = 8'h13;
        hif.wdata = 8'hC3;
        @(negedge clock);
        hif.start = 1'b0;
        n = 0;
        while (srises < 11 && n < 2000) begin
            n++;
            @(negedge clock);
        end
        chk("rstmid_reached", 32'(srises), 32'd11);
        n_reset = 1'b0;
        #1;
        chk("rstmid_ss", 32'(ss), 32'd1);
        chk("rstmid_sclk", 32'(sclk), 32'd0);
        chk("rstmid_mosi", 32'(mosi), 32'd0);
        chk("rstmid_busy", 32'(hif.busy), 32'd0);
        @(negedge clock);
        n_reset = 1'b1;
        @(negedge clock);
        txn(1'b1, 8'h13, 8'h00, bc, dn, rdv);
        chk("rstmid_read", 32'(rdv), 32'h3C);
        chk("rstmid_rises", 32'(last_rises), 32'd24);

`ifdef SPI_MASTER_ABORT_EN
        // abort a read at bit 12: rdata must keep 0x3C
        @(negedge clock);
        hif.start = 1'b1;
        hif.rw    = 1'b1;
        hif.addr  = 8'h20;
        @(negedge clock);
        hif.start = 1'b0;
        n = 0;
        while (srises < 13 && n < 2000) begin
            n++;
            @(negedge clock);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abt_ss", 32'(ss), 32'd1);
        chk("abt_sclk", 32'(sclk), 32'd0);
        chk("abt_mosi", 32'(mosi), 32'd0);
        n = 0;
        while (hif.done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("abt_gap", 32'(n), 32'd8);
        chk("abt_aborted", 32'(aborted), 32'd1);
        chk("abt_rdata", 32'(hif.rdata), 32'h3C);
        chk("abt_rises", 32'(last_rises), 32'd13);
        @(negedge clock);
        txn(1'b1, 8'h10, 8'h00, bc, dn, rdv);
        chk("abt_next_rdata", 32'(rdv), 32'hA5);
        chk("abt_next_flag", 32'(aborted), 32'd0);
`endif

        chk("sclk_while_ss_high", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
